// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the 8-bit accumulator datapath.
// Holds the instruction register and the memory data register, drives the
// datapath strobes and PC write enable, handshakes with data memory and
// traps on ALU overflow or memory timeout.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start
// FETCH   | latch inst_in into ir
// DECODE  | one decode cycle; HALT encoding parks the sequencer
// EXEC    | ALU operation, jump, or branch/memory setup
// BRWAIT  | branch flag now registered; select PC source and write PC
// MEM     | data-memory request outstanding, timeout counter running
// WB      | write load data back to the accumulator file
// HALT    | HALT executed; only rst leaves
// ERR     | overflow or memory timeout trapped; only rst leaves
module multicycle_ctrl #(
  parameter bit          TRAP_OVF    = 1'b1,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [8:0] inst_in,
  input  logic       overflow,
  input  logic       BranchFlag,
  input  logic       mem_ready,
  input  logic [7:0] mem_rdata,
  output logic [8:0] ir,
  output logic [7:0] read_data_q,
  output logic       MemToReg,
  output logic       PcSrc,
  output logic       ALUSrc,
  output logic       RegWrite,
  output logic       Jump,
  output logic       PcWrite,
  output logic [2:0] ALUControl,
  output logic [2:0] AccControl,
  output logic       mem_req,
  output logic       mem_we,
  output logic       halted,
  output logic       err,
  output logic [15:0] retired
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_BRWAIT, S_MEM, S_WB, S_HALT, S_ERR
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_BEQ  = 3'b011;
  localparam logic [2:0] OP_ADDI = 3'b100;
  localparam logic [2:0] OP_LW   = 3'b101;
  localparam logic [2:0] OP_SW   = 3'b110;
  localparam logic [2:0] OP_J    = 3'b111;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;

  localparam logic [8:0] HALT_INST = 9'h1FF;
  localparam logic [7:0] TMO_LIMIT = 8'(MEM_TIMEOUT);

  state_t     state, state_nxt;
  logic [7:0] tmo_cnt;
  logic [7:0] tmo_next;
  logic [2:0] op;
  logic       alu_src_dec;
  logic [2:0] alu_ctl_dec;
  logic       ovf_trap;

  assign op       = ir[8:6];
  assign tmo_next = tmo_cnt + 8'd1;

  // ALU operand/operation decode shared by EXEC and MEM (address held stable)
  always_comb begin
    alu_src_dec = (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
    if (op == OP_SUB || op == OP_BEQ) alu_ctl_dec = ALU_SUB;
    else if (op == OP_AND)            alu_ctl_dec = ALU_AND;
    else                              alu_ctl_dec = ALU_ADD;
  end

  // AND cannot overflow, so only the arithmetic opcodes can trap
  assign ovf_trap = TRAP_OVF && overflow && (op != OP_AND);

  // Next-state and strobe decode from state and ir
  always_comb begin
    state_nxt  = state;
    MemToReg   = 1'b0;
    PcSrc      = 1'b0;
    ALUSrc     = 1'b0;
    RegWrite   = 1'b0;
    Jump       = 1'b0;
    PcWrite    = 1'b0;
    ALUControl = 3'b000;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    case (state)
      S_IDLE:   if (start) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: state_nxt = (ir == HALT_INST) ? S_HALT : S_EXEC;
      S_EXEC: begin
        ALUSrc     = alu_src_dec;
        ALUControl = alu_ctl_dec;
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_ADDI: begin
            if (ovf_trap) begin
              state_nxt = S_ERR;
            end else begin
              RegWrite  = 1'b1;
              PcWrite   = 1'b1;
              state_nxt = S_FETCH;
            end
          end
          OP_BEQ: state_nxt = S_BRWAIT;
          OP_J: begin
            Jump      = 1'b1;
            PcWrite   = 1'b1;
            state_nxt = S_FETCH;
          end
          default: state_nxt = S_MEM;
        endcase
      end
      S_BRWAIT: begin
        PcSrc     = BranchFlag;
        PcWrite   = 1'b1;
        state_nxt = S_FETCH;
      end
      S_MEM: begin
        ALUSrc     = alu_src_dec;
        ALUControl = alu_ctl_dec;
        mem_req    = 1'b1;
        mem_we     = (op == OP_SW);
        if (mem_ready) begin
          if (op == OP_SW) begin
            PcWrite   = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_WB;
          end
        end else if (tmo_next == TMO_LIMIT) begin
          state_nxt = S_ERR;
        end
      end
      S_WB: begin
        MemToReg  = 1'b1;
        RegWrite  = 1'b1;
        PcWrite   = 1'b1;
        state_nxt = S_FETCH;
      end
      default: state_nxt = state;
    endcase
  end

  assign AccControl = RegWrite ? ir[5:3] : 3'b000;
  assign halted     = (state == S_HALT);
  assign err        = (state == S_ERR);

  // State, IR, MDR, memory timeout counter and retired-instruction count
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      ir          <= 9'd0;
      read_data_q <= 8'd0;
      tmo_cnt     <= 8'd0;
      retired     <= 16'd0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH) ir <= inst_in;
      if (state == S_MEM) begin
        if (mem_ready) begin
          tmo_cnt <= 8'd0;
          if (op == OP_LW) read_data_q <= mem_rdata;
        end else begin
          tmo_cnt <= tmo_next;
        end
      end
      if (PcWrite) retired <= retired + 16'd1;
    end
  end

endmodule
